trdb_packet_scheduler: RTL and testbench

- Sequences packet requests into trdb_packet_emitter: one packet per handshake, fixed priority, held selection until accepted.
- Owns the trace on/off protocol: on enable, F3/SF_SUPPORT (ienable=1) then F3/SF_START; on disable, F3/SF_SUPPORT (ienable=0).
- Generates periodic resync (F3/SF_START) requests and the branch-map flush pulse.

---
 rtl/trdb_packet_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_trdb_packet_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_packet_scheduler.sv
// trdb_packet_scheduler: sequences trace on/off protocol packets, periodic
// resyncs and requested packets into the packet emitter, one per handshake.
module trdb_packet_scheduler #(
    parameter int unsigned RESYNC_MAX   = 256,
    parameter int unsigned RESYNC_CNT_W = $clog2(RESYNC_MAX)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       trap_req_i,
    input  logic       addr_req_i,
    input  logic       bmap_full_req_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [1:0] packet_format_o,
    output logic [1:0] packet_f_sync_subformat_o,
    output logic       ienable_o,
    output logic       branch_map_flush_o,
    output logic       lost_o
);

    localparam logic [1:0] F_OPT_EXT    = 2'd0;
    localparam logic [1:0] F_DIFF_DELTA = 2'd1;
    localparam logic [1:0] F_ADDR_ONLY  = 2'd2;
    localparam logic [1:0] F_SYNC       = 2'd3;

    localparam logic [1:0] SF_START   = 2'd0;
    localparam logic [1:0] SF_TRAP    = 2'd1;
    localparam logic [1:0] SF_SUPPORT = 2'd3;

    localparam logic [RESYNC_CNT_W-1:0] CNT_LAST = RESYNC_CNT_W'(RESYNC_MAX - 1);

    // Pending-flag bit positions double as the selection code; lower is higher priority.
    typedef enum logic [1:0] {
        SEL_TRAP   = 2'd0,
        SEL_RESYNC = 2'd1,
        SEL_ADDR   = 2'd2,
        SEL_BMAP   = 2'd3
    } sel_e;

    typedef enum logic [2:0] {
        IDLE,
        SUPPORT_ON,
        START,
        RUN,
        SUPPORT_OFF
    } state_e;

    state_e                  state_q;
    logic [3:0]              pend_q;
    logic                    lock_q;
    sel_e                    lock_sel_q;
    logic [RESYNC_CNT_W-1:0] cnt_q;
    logic                    flush_q;
    logic                    lost_q;

    sel_e       sel;
    logic       accept;
    logic       resync_hit;
    logic [3:0] req;
    logic [3:0] clr;
    logic [3:0] pend_nxt;
    logic       drop;
    logic       leave_run;

    assign branch_map_flush_o = flush_q;
    assign lost_o             = lost_q;

    // Held selection while locked, otherwise fixed priority over pending flags.
    always_comb begin
        sel = SEL_BMAP;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (pend_q[SEL_TRAP]) begin
            sel = SEL_TRAP;
        end else if (pend_q[SEL_RESYNC]) begin
            sel = SEL_RESYNC;
        end else if (pend_q[SEL_ADDR]) begin
            sel = SEL_ADDR;
        end
    end

    // Packet request decode from state, flags and lock.
    always_comb begin
        valid_o                   = 1'b0;
        packet_format_o           = F_OPT_EXT;
        packet_f_sync_subformat_o = SF_START;
        ienable_o                 = 1'b0;
        case (state_q)
            SUPPORT_ON: begin
                valid_o                   = 1'b1;
                packet_format_o           = F_SYNC;
                packet_f_sync_subformat_o = SF_SUPPORT;
                ienable_o                 = 1'b1;
            end
            START: begin
                valid_o         = 1'b1;
                packet_format_o = F_SYNC;
            end
            SUPPORT_OFF: begin
                valid_o                   = 1'b1;
                packet_format_o           = F_SYNC;
                packet_f_sync_subformat_o = SF_SUPPORT;
            end
            RUN: begin
                if (lock_q || (|pend_q)) begin
                    valid_o = 1'b1;
                    case (sel)
                        SEL_TRAP: begin
                            packet_format_o           = F_SYNC;
                            packet_f_sync_subformat_o = SF_TRAP;
                        end
                        SEL_RESYNC: packet_format_o = F_SYNC;
                        SEL_ADDR:   packet_format_o = F_ADDR_ONLY;
                        default:    packet_format_o = F_DIFF_DELTA;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Flag bookkeeping for RUN: set wins over the clear of an accepted packet.
    always_comb begin
        accept     = valid_o && ready_i;
        resync_hit = (cnt_q == CNT_LAST);
        req        = {bmap_full_req_i, addr_req_i, resync_hit, trap_req_i};
        clr        = 4'b0000;
        if (accept) begin
            clr[sel] = 1'b1;
            if (sel == SEL_TRAP) begin
                clr[SEL_RESYNC] = 1'b1;
            end
        end
        pend_nxt  = (pend_q & ~clr) | req;
        drop      = |(req & pend_q & ~clr & 4'b1101);
        leave_run = !enable_i && (!valid_o || accept);
    end

    // Protocol FSM, pending flags, selection lock, resync counter and pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pend_q     <= 4'b0000;
            lock_q     <= 1'b0;
            lock_sel_q <= SEL_TRAP;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            lost_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    pend_q <= 4'b0000;
                    lock_q <= 1'b0;
                    cnt_q  <= '0;
                    if (enable_i) begin
                        state_q <= SUPPORT_ON;
                    end
                end
                SUPPORT_ON: begin
                    if (accept) begin
                        state_q <= enable_i ? START : SUPPORT_OFF;
                    end
                end
                START: begin
                    if (accept) begin
                        flush_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= enable_i ? RUN : SUPPORT_OFF;
                    end
                end
                RUN: begin
                    if (accept && (sel == SEL_TRAP || sel == SEL_RESYNC)) begin
                        cnt_q <= '0;
                    end else if (resync_hit) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + RESYNC_CNT_W'(1);
                    end

                    if (accept) begin
                        lock_q <= 1'b0;
                    end else if (valid_o && !lock_q) begin
                        lock_q     <= 1'b1;
                        lock_sel_q <= sel;
                    end

                    flush_q <= accept && (sel != SEL_ADDR);

                    if (leave_run) begin
                        state_q <= SUPPORT_OFF;
                        pend_q  <= 4'b0000;
                        lost_q  <= drop || (|pend_nxt);
                    end else begin
                        pend_q <= pend_nxt;
                        lost_q <= drop;
                    end
                end
                SUPPORT_OFF: begin
                    if (accept) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Testbench for trdb_packet_scheduler: directed protocol scenarios followed by
// randomized traffic, all checked against a packet-level reference model.
module tb_trdb_packet_scheduler;

    localparam int unsigned RM = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       tr  = 1'b0;
    logic       ad  = 1'b0;
    logic       bm  = 1'b0;
    logic       rdy = 1'b0;
    logic       valid;
    logic [1:0] fmt;
    logic [1:0] sub;
    logic       ien;
    logic       flush;
    logic       lost;

    trdb_packet_scheduler #(.RESYNC_MAX(RM)) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .enable_i                  (en),
        .trap_req_i                (tr),
        .addr_req_i                (ad),
        .bmap_full_req_i           (bm),
        .ready_i                   (rdy),
        .valid_o                   (valid),
        .packet_format_o           (fmt),
        .packet_f_sync_subformat_o (sub),
        .ienable_o                 (ien),
        .branch_map_flush_o        (flush),
        .lost_o                    (lost)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model phases of the trace session.
    localparam int P_IDLE  = 0;
    localparam int P_ON    = 1;
    localparam int P_START = 2;
    localparam int P_RUN   = 3;
    localparam int P_OFF   = 4;

    // Packet kinds: 0 trap, 1 resync, 2 address-only, 3 branch map.
    int ph      = P_IDLE;
    bit pend[4];
    int held    = -1;
    int age     = 0;
    bit m_flush = 1'b0;
    bit m_lost  = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cur_kind();
        if (ph != P_RUN) return -1;
        if (held >= 0) return held;
        for (int k = 0; k < 4; k++) if (pend[k]) return k;
        return -1;
    endfunction

    function automatic bit [1:0] kind_fmt(input int k);
        case (k)
            0, 1:    return 2'd3;
            2:       return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    function automatic bit [1:0] kind_sub(input int k);
        return (k == 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic expect_out(output bit v, output bit [1:0] f, output bit [1:0] s, output bit ie);
        int k;
        v = 1'b0; f = 2'd0; s = 2'd0; ie = 1'b0;
        k = cur_kind();
        case (ph)
            P_ON:    begin v = 1'b1; f = 2'd3; s = 2'd3; ie = 1'b1; end
            P_START: begin v = 1'b1; f = 2'd3; s = 2'd0; end
            P_OFF:   begin v = 1'b1; f = 2'd3; s = 2'd3; end
            P_RUN:   if (k >= 0) begin v = 1'b1; f = kind_fmt(k); s = kind_sub(k); end
            default: ;
        endcase
    endtask

    task automatic model_step(input bit e, input bit t, input bit a, input bit b,
                              input bit r, input bit v);
        bit acc;
        int cur;
        bit req[4];
        bit nf;
        bit nl;
        acc = v && r;
        nf  = 1'b0;
        nl  = 1'b0;
        case (ph)
            P_IDLE:  if (e) ph = P_ON;
            P_ON:    if (acc) ph = e ? P_START : P_OFF;
            P_START: if (acc) begin nf = 1'b1; age = 0; ph = e ? P_RUN : P_OFF; end
            P_RUN: begin
                cur    = cur_kind();
                req[0] = t;
                req[1] = (age == int'(RM) - 1);
                req[2] = a;
                req[3] = b;
                for (int k = 0; k < 4; k++)
                    if (k != 1 && req[k] && pend[k] && !(acc && cur == k)) nl = 1'b1;
                if (acc) begin
                    pend[cur] = 1'b0;
                    if (cur == 0) pend[1] = 1'b0;
                    nf   = (cur != 2);
                    held = -1;
                end else if (v) begin
                    held = cur;
                end
                if (acc && cur <= 1) age = 0;
                else if (age == int'(RM) - 1) age = 0;
                else age++;
                for (int k = 0; k < 4; k++) if (req[k]) pend[k] = 1'b1;
                if (!e && (!v || acc)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (pend[k]) nl = 1'b1;
                        pend[k] = 1'b0;
                    end
                    held = -1;
                    ph   = P_OFF;
                end
            end
            P_OFF:   if (acc) ph = P_IDLE;
            default: ph = P_IDLE;
        endcase
        m_flush = nf;
        m_lost  = nl;
    endtask

    // Check the current cycle's outputs, drive inputs for the next edge, advance.
    task automatic cycle(input bit e, input bit t, input bit a, input bit b, input bit r);
        bit v;
        bit [1:0] f;
        bit [1:0] s;
        bit ie;
        expect_out(v, f, s, ie);
        chk("valid",     8'(valid), 8'(v));
        chk("format",    8'(fmt),   8'(f));
        chk("subformat", 8'(sub),   8'(s));
        chk("ienable",   8'(ien),   8'(ie));
        chk("flush",     8'(flush), 8'(m_flush));
        chk("lost",      8'(lost),  8'(m_lost));
        en = e; tr = t; ad = a; bm = b; rdy = r;
        model_step(e, t, a, b, r, v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit e, input bit r);
        rst = 1'b1; en = e; tr = 1'b0; ad = 1'b0; bm = 1'b0; rdy = r;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ph      = P_IDLE;
        held    = -1;
        age     = 0;
        m_flush = 1'b0;
        m_lost  = 1'b0;
        for (int k = 0; k < 4; k++) pend[k] = 1'b0;
    endtask

    initial begin
        bit re;
        for (int k = 0; k < 4; k++) pend[k] = 1'b0;

        // Enable sequence: support-on, start, then RUN with a flush.
        do_reset(1'b0, 1'b1);
        chk("rst_valid", 8'(valid), 8'd0);
        cycle(1, 0, 0, 0, 1);
        chk("t1_on_sub", 8'(sub), 8'd3);
        chk("t1_on_ien", 8'(ien), 8'd1);
        cycle(1, 0, 0, 0, 1);
        chk("t1_start_fmt", 8'(fmt), 8'd3);
        chk("t1_start_sub", 8'(sub), 8'd0);
        cycle(1, 0, 0, 0, 1);
        chk("t1_run_flush", 8'(flush), 8'd1);

        // Locked address packet holds off a later trap; no flush after addr.
        cycle(1, 0, 1, 0, 0);
        chk("t2_addr_fmt", 8'(fmt), 8'd2);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        chk("t2_addr_held", 8'(fmt), 8'd2);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        chk("t2_trap_fmt", 8'(fmt), 8'd3);
        chk("t2_trap_sub", 8'(sub), 8'd1);
        chk("t2_no_flush", 8'(flush), 8'd0);
        cycle(1, 0, 0, 0, 1);
        chk("t2_trap_flush", 8'(flush), 8'd1);

        // Duplicate branch-map request while stalled is dropped.
        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        chk("t3_lost", 8'(lost), 8'd1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1);

        // Free-running resyncs, then a trap restarting the interval.
        for (int i = 0; i < 30; i++) cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 25; i++) cycle(1, 0, 0, 0, 1);

        // Disable while a packet is held: finish it, then support-off, idle.
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1);
        chk("t5_idle_valid", 8'(valid), 8'd0);
        chk("t5_idle_ien", 8'(ien), 8'd0);

        // Reset in the middle of the support-on handshake.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("t6_on_valid", 8'(valid), 8'd1);
        do_reset(1'b1, 1'b0);
        chk("t6_rst_valid", 8'(valid), 8'd0);
        cycle(1, 0, 0, 0, 0);
        chk("t6_restart_sub", 8'(sub), 8'd3);
        chk("t6_restart_ien", 8'(ien), 8'd1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1);

        // Randomized traffic with occasional enable toggles and resets.
        re = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) re = ~re;
            if ($urandom_range(699) == 0) begin
                do_reset(re, 1'($urandom_range(1)));
            end else begin
                cycle(re, $urandom_range(7) == 0, $urandom_range(7) == 0,
                      $urandom_range(7) == 0, $urandom_range(2) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
